// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
//   DIGIT_W     : width of one lookahead digit (nibble)
//   sub_state_e : control states of the digit-serial subtractor
package arith_pkg;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sub_state_e;
endpackage

// File: rtl/cla_sub4_slice.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bw_in (mod 16).
// This is the subtract-direction twin of the 4-bit carry-lookahead adder.
// Every internal borrow is a two-level sum of products of g/p/bw_in,
// so there is no ripple path through the nibble.
//   a, b   : minuend / subtrahend digit
//   bw_in  : borrow into bit 0
//   d      : difference digit
//   bw_out : borrow out of bit 3
module cla_sub4_slice
    import arith_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               bw_in,
    output logic [DIGIT_W-1:0] d,
    output logic               bw_out
);
    logic [DIGIT_W-1:0] g;
    logic [DIGIT_W-1:0] p;
    logic [DIGIT_W:0]   bw;

    // A bit generates a borrow when it is 0 and the subtrahend bit is 1.
    // It passes an incoming borrow on when the two bits are equal.
    assign g = ~a & b;
    assign p = ~(a ^ b);

    always_comb begin
        bw    = '0;
        bw[0] = bw_in;
        bw[1] = g[0] | (p[0] & bw_in);
        bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bw_in);
        bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bw_in);
        bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bw_in);
    end

    assign d      = a ^ b ^ bw[DIGIT_W-1:0];
    assign bw_out = bw[DIGIT_W];
endmodule

// File: rtl/cla_serial_subtractor.sv
// Digit-serial WIDTH-bit subtractor: diff = a - b - b_in (mod 2^WIDTH).
// One 4-bit borrow-lookahead slice is shared across all digits and works
// through them LSB first, one digit per cycle. Only one operation is in
// flight at a time.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, b_in)
//   out_valid/out_ready : result handshake (diff, b_out, overflow)
//   b_out               : unsigned borrow, 1 iff a < b + b_in
//   overflow            : two's-complement overflow of the subtraction
module cla_serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow
);
    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NDIG - 1);

    if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_width
        $error("cla_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end

    sub_state_e state, state_nxt;

    logic [NDIG-1:0][DIGIT_W-1:0] a_r;
    logic [NDIG-1:0][DIGIT_W-1:0] b_r;
    logic [NDIG-1:0][DIGIT_W-1:0] diff_r;
    logic [IDXW-1:0]              idx;
    logic                         bw_r;
    logic                         b_out_r;
    logic                         ovf_r;

    logic [DIGIT_W-1:0] slice_d;
    logic               slice_bw;

    cla_sub4_slice u_slice (
        .a      (a_r[idx]),
        .b      (b_r[idx]),
        .bw_in  (bw_r),
        .d      (slice_d),
        .bw_out (slice_bw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            diff_r  <= '0;
            idx     <= '0;
            bw_r    <= 1'b0;
            b_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        bw_r <= b_in;
                        idx  <= '0;
                    end
                end
                BUSY: begin
                    diff_r[idx] <= slice_d;
                    bw_r        <= slice_bw;
                    idx         <= idx + 1'b1;
                    if (idx == LAST) begin
                        // Keep idx in range for non-power-of-two digit counts.
                        idx     <= '0;
                        b_out_r <= slice_bw;
                        // Operands of opposite sign whose result sign differs
                        // from the minuend's have wrapped.
                        ovf_r   <= (a_r[NDIG-1][DIGIT_W-1] != b_r[NDIG-1][DIGIT_W-1])
                                && (slice_d[DIGIT_W-1] != a_r[NDIG-1][DIGIT_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff     = diff_r;
    assign b_out    = b_out_r;
    assign overflow = ovf_r;
endmodule

// File: tb/tb_cla_serial_subtractor.sv
module tb_cla_serial_subtractor;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cla_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one cycle; returns once the accept edge has passed.
    task automatic accept(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic bi);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        b_in     = bi;
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    // Count cycles from the accept edge until out_valid; expect NDIG=4.
    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 16'(cyc), 16'd4);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] d,
                                input logic bo, input logic ov);
        chk({tag, "_diff"}, diff, d);
        chk({tag, "_b_out"}, {15'd0, b_out}, {15'd0, bo});
        chk({tag, "_ovf"}, {15'd0, overflow}, {15'd0, ov});
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_retired_valid"}, {15'd0, out_valid}, 16'd0);
        chk({tag, "_retired_ready"}, {15'd0, in_ready}, 16'd1);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic bi,
                          input logic [WIDTH-1:0] d, input logic bo, input logic ov);
        accept(tag, av, bv, bi);
        wait_done(tag);
        check_result(tag, d, bo, ov);
        retire(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        #3;
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_diff", diff, 16'h0000);
        chk("rst_b_out", {15'd0, b_out}, 16'd0);
        chk("rst_ovf", {15'd0, overflow}, 16'd0);
        #9 rst_n = 1'b1;
        tick();

        run_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        // diff holds the last result after retire
        tick();
        chk("diff_hold_idle", diff, 16'h1000);

        run_op("ripple", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // in_valid during BUSY is ignored
        accept("bin", 16'h0005, 16'h0005, 1'b1);
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h0001;
        b_in     = 1'b0;
        chk("busy_in_ready", {15'd0, in_ready}, 16'd0);
        tick();
        in_valid = 1'b0;
        chk("busy_in_ready2", {15'd0, in_ready}, 16'd0);
        begin
            int cyc;
            cyc = 1;
            while (!out_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("bin_latency", 16'(cyc), 16'd4);
        end
        check_result("bin", 16'hFFFF, 1'b1, 1'b0);
        chk("done_in_ready", {15'd0, in_ready}, 16'd0);
        retire("bin");
        tick();
        chk("no_ghost_op", {15'd0, in_ready}, 16'd1);

        // backpressure: 0x00FF - 0x0F0F = 0xF1F0 with borrow
        accept("bp", 16'h00FF, 16'h0F0F, 1'b0);
        wait_done("bp");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {15'd0, out_valid}, 16'd1);
            check_result("bp_hold", 16'hF1F0, 1'b1, 1'b0);
        end
        retire("bp");

        // asynchronous reset mid-operation at idx=2
        accept("rst_mid", 16'hFFFF, 16'h0001, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {15'd0, out_valid}, 16'd0);
        chk("midrst_ready", {15'd0, in_ready}, 16'd1);
        chk("midrst_diff", diff, 16'h0000);
        chk("midrst_b_out", {15'd0, b_out}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", {15'd0, out_valid}, 16'd0);
        run_op("after_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cla_serial_subtractor.md
Name: cla_serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor: diff = a - b - b_in, processed one 4-bit digit per cycle, LSB digit first.
- Each digit uses a 4-bit borrow-lookahead slice, the subtract-direction counterpart of the team's 4-bit carry-lookahead adder.
- Valid/ready handshake on input and output; one operation in flight at a time.
- Sits in the arithmetic datapath alongside the lookahead adders.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4, otherwise elaboration error.
- NDIG, WIDTH/4, derived digit count; localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- b_in  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - b_in, modulo 2^WIDTH
- b_out  output  1  unsigned borrow out; 1 iff a < b + b_in
- overflow  output  1  signed overflow: a[W-1] != b[W-1] and diff[W-1] != a[W-1]

Behaviour:
- Reset: clk and rst_n are the only clock and reset. rst_n is asynchronous and active-low.
  - On reset: FSM goes to IDLE; in_ready=1, out_valid=0; diff, b_out and overflow are 0; digit counter and borrow register are 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: register a, b and b_in; set borrow register to b_in; set digit index to 0; go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle the slice combines digit[idx] of a and b with the borrow register.
  - diff nibble idx and the borrow register are written; idx increments.
  - When idx == NDIG-1: latch b_out from the slice borrow out, compute overflow from the final sign bits, and go to DONE.
- DONE:
  - out_valid=1; diff, b_out and overflow are held stable.
  - On out_ready: go to IDLE; out_valid falls on the next edge.
- Latency: operands accepted at edge k; out_valid=1 after edge k+NDIG (4 cycles for WIDTH=16).
- Throughput: at most 1 result every NDIG+2 cycles, including the accept and retire cycles.
- Boundary conditions:
  - in_valid while BUSY or DONE: ignored, not queued; a and b may change freely.
  - out_ready while not DONE: no effect.
  - out_ready held low in DONE: stay in DONE indefinitely, outputs unchanged.
  - No same-cycle retire-and-accept: in_ready=0 in DONE.
  - Reset mid-operation: partial result discarded, outputs return to reset values, no out_valid pulse.
  - diff retains the last result after retire until the next operation overwrites it nibble by nibble. Consumers sample only under out_valid.
- Borrow-lookahead slice arithmetic, per bit i:
  - generate g_i = ~a_i & b_i
  - propagate p_i = ~(a_i ^ b_i)
  - d_i = a_i ^ b_i ^ bw_i
  - bw_{i+1} = g_i | p_i & bw_i, fully expanded to two-level lookahead for bw_1..bw_4; no ripple chain.

Decomposition:
- Shared package arith_pkg holds:
  - FSM state enum sub_state_e {IDLE, BUSY, DONE}
  - DIGIT_W = 4
- Sub-module cla_sub4_slice: purely combinational.
  - Inputs: 4-bit a, 4-bit b, bw_in.
  - Outputs: 4-bit d, bw_out.
  - Instantiated once and shared across digits via the digit-index mux.

Test Plan (WIDTH=16):
- a=0x1234, b=0x0234, b_in=0 -> diff=0x1000, b_out=0, overflow=0; out_valid exactly 4 cycles after accept.
- a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1, overflow=0 (borrow ripples through all 4 digits).
- a=0x8000, b=0x0001, b_in=0 -> diff=0x7FFF, b_out=0, overflow=1; and a=0x7FFF, b=0xFFFF -> diff=0x8000, b_out=1, overflow=1.
- a=0x0005, b=0x0005, b_in=1 -> diff=0xFFFF, b_out=1; in_valid pulsed during BUSY with other operands -> ignored, in_ready stays 0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, diff, b_out and overflow stable; out_ready=1 -> IDLE next edge, in_ready=1.
- Assert rst_n low asynchronously at idx=2 of a=0xFFFF-0x0001 -> immediate out_valid=0, in_ready=1, diff=0; next op 0x0010-0x0001 -> diff=0x000F.
